// File: rtl/cpuDefine.sv
// Shared CPU type definitions: the machine data word, divider iteration count
// and a conditional absolute-value helper.
package cpuDefine;

  typedef logic [31:0] DType;

  localparam int DIV_ITER = 32;

  // Two's-complement magnitude when s is set; the value unchanged otherwise.
  function automatic DType abs_val(input DType v, input logic s);
    if (s && v[31]) begin
      abs_val = DType'(32'd0 - v);
    end else begin
      abs_val = v;
    end
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/MOD/MODU. One quotient
// bit per cycle; signs are stripped at capture and restored on the last step.
module seq_divider
  import cpuDefine::*;
(
  input  logic aclk,
  input  logic aresetn,
  input  logic en,
  input  logic is_signed,
  input  DType dividend,
  input  DType divisor,
  output DType quotient,
  output DType remainder,
  output logic complete
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [63:0] r_acc;
  DType        r_dvsr;
  DType        r_dvdd;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [5:0]  r_cnt;
  DType        r_quot;
  DType        r_rem;
  logic        r_complete;

  logic [63:0] w_shift;
  logic [32:0] w_diff;
  logic [63:0] w_step;
  logic        w_last;
  DType        w_q_fix;
  DType        w_r_fix;

  // One restoring step: shift, trial-subtract, keep the difference if no borrow.
  always_comb begin
    w_shift = {r_acc[62:0], 1'b0};
    w_diff  = {1'b0, w_shift[63:32]} - {1'b0, r_dvsr};
    if (w_diff[32]) begin
      w_step = w_shift;
    end else begin
      w_step = {w_diff[31:0], w_shift[31:1], 1'b1};
    end
    w_last = (r_cnt == 6'(DIV_ITER - 1));
  end

  // Sign fixup of the final step; a zero divisor bypasses it and returns the raw dividend.
  always_comb begin
    if (r_dvsr == 32'd0) begin
      w_q_fix = 32'hFFFF_FFFF;
      w_r_fix = r_dvdd;
    end else begin
      w_q_fix = r_neg_q ? DType'(32'd0 - w_step[31:0])  : w_step[31:0];
      w_r_fix = r_neg_r ? DType'(32'd0 - w_step[63:32]) : w_step[63:32];
    end
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; dropping en while busy abandons the operation.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_next_state = BUSY;
        end else begin
          w_next_state = IDLE;
        end
      end
      BUSY: begin
        if (!en) begin
          w_next_state = IDLE;
        end else if (w_last) begin
          w_next_state = DONE;
        end else begin
          w_next_state = BUSY;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and registered results.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_acc      <= 64'd0;
      r_dvsr     <= 32'd0;
      r_dvdd     <= 32'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_cnt      <= 6'd0;
      r_quot     <= 32'd0;
      r_rem      <= 32'd0;
      r_complete <= 1'b0;
    end else begin
      r_complete <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en) begin
            r_acc   <= {32'd0, abs_val(dividend, is_signed)};
            r_dvsr  <= abs_val(divisor, is_signed);
            r_dvdd  <= dividend;
            r_neg_q <= is_signed & (dividend[31] ^ divisor[31]);
            r_neg_r <= is_signed & dividend[31];
            r_cnt   <= 6'd0;
          end else begin
            r_cnt <= r_cnt;
          end
        end
        BUSY: begin
          if (en) begin
            r_acc <= w_step;
            r_cnt <= r_cnt + 6'd1;
            if (w_last) begin
              r_quot     <= w_q_fix;
              r_rem      <= w_r_fix;
              r_complete <= 1'b1;
            end else begin
              r_complete <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign complete  = r_complete;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver queues hand-computed results with
// their expected completion cycle; a negedge monitor pops on every complete pulse.
module tb_seq_divider;

  logic        aclk;
  logic        aresetn;
  logic        en;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        complete;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  seq_divider dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .en        (en),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .complete  (complete)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every complete pulse must match the oldest queued expectation.
  always @(negedge aclk) begin
    if (complete === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_complete: got complete=1 at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_complete(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk);
      if (complete === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: got no complete in 40 cycles, expected one", name);
    end
  endtask

  task automatic run_op(input string name, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
    exp_t e;
    @(negedge aclk);
    en = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(posedge aclk); #1;
    e.q = eq; e.r = er; e.cyc = cyc + 32;
    sb.push_back(e);
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = ~s;
    wait_complete(name);
    en = 1'b0;
  endtask

  task automatic quiet_window(input int n);
    for (int i = 0; i < n; i++) @(negedge aclk);
  endtask

  initial begin
    exp_t e;
    aresetn = 1'b0; en = 1'b1; is_signed = 1'b0;
    dividend = 32'd100; divisor = 32'd7;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_complete", {31'd0, complete}, 32'd0);
    en = 1'b0;
    aresetn = 1'b1;

    run_op("udiv_100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2);
    run_op("sdiv_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF);
    run_op("udiv_fff9_2",  1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1);
    run_op("sdiv_100_m7",  1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2);
    run_op("sdiv_m100_m7", 1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE);
    run_op("sdiv_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0);
    run_op("udiv_8000_ff", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000);
    run_op("udiv_zero",    1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678);
    run_op("sdiv_zero",    1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678);
    run_op("sdiv_zero_neg",1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9);

    quiet_window(5);
    check("hold_quotient", quotient, 32'hFFFF_FFFF);
    check("hold_remainder", remainder, 32'hFFFF_FFF9);

    // Back-to-back: en stays high through complete, new operands the cycle after.
    @(negedge aclk);
    en = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd10;
    @(posedge aclk); #1;
    e.q = 32'd100; e.r = 32'd0; e.cyc = cyc + 32;
    sb.push_back(e);
    wait_complete("b2b_first");
    e.q = 32'd3; e.r = 32'd0; e.cyc = cyc + 34;
    sb.push_back(e);
    @(negedge aclk);
    dividend = 32'd9; divisor = 32'd3;
    wait_complete("b2b_second");
    en = 1'b0;

    // Abort: en low at the 10th BUSY edge.
    @(negedge aclk);
    en = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge aclk);
    repeat (9) @(posedge aclk);
    @(negedge aclk);
    en = 1'b0;
    quiet_window(45);
    check("abort_quotient", quotient, 32'd3);
    check("abort_remainder", remainder, 32'd0);
    run_op("after_abort",  1'b0, 32'd50, 32'd5, 32'd10, 32'd0);

    // Reset in the middle of BUSY.
    @(negedge aclk);
    en = 1'b1; dividend = 32'd77; divisor = 32'd3;
    @(posedge aclk);
    repeat (5) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_complete", {31'd0, complete}, 32'd0);
    @(negedge aclk);
    aresetn = 1'b1; en = 1'b0;
    quiet_window(45);
    check("rst_hold_quotient", quotient, 32'd0);
    run_op("after_reset",  1'b0, 32'd77, 32'd3, 32'd25, 32'd2);

    quiet_window(40);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test by 200000 ns, expected earlier finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 aclk  input  1  sole clock; all state updates on rising edge.
REQ-002 aresetn  input  1  reset, synchronous, active-low.
REQ-003 en  input  1  level request from ALU; high while a DIV/DIVU/MOD/MODU op sits in the execute stage.
REQ-004 is_signed  input  1  1 = two's-complement divide, 0 = unsigned.
REQ-005 dividend  input  32  DType numerator.
REQ-006 divisor  input  32  DType denominator.
REQ-007 quotient  output  32  DType result, registered.
REQ-008 remainder  output  32  DType result, registered.
REQ-009 complete  output  1  one-cycle pulse; quotient/remainder valid in the same cycle.

Function
REQ-010 FSM states: IDLE, BUSY, DONE.
REQ-011 IDLE, en=1 at edge: capture operands; capture is_signed; capture signs; capture |dividend| and |divisor| (abs only when is_signed); clear 6-bit iteration counter; go to BUSY.
REQ-012 IDLE, en=0: stay in IDLE; outputs hold.
REQ-013 BUSY: one radix-2 restoring step per cycle on 64-bit partial-remainder/quotient register; counter increments.
REQ-014 BUSY: after 32nd step, apply sign fixup, load quotient/remainder, go to DONE.
REQ-015 Latency: complete is high in the cycle after the 33rd edge counting the capture edge as edge 1.
REQ-016 DONE: complete=1 for exactly that cycle.
REQ-017 DONE: go to IDLE unconditionally, regardless of en.
REQ-018 After DONE, en is held high only by the op already being retired, so DONE never re-captures.
REQ-019 Back-to-back ops restart from IDLE, so successive complete pulses are at least 34 edges apart.
REQ-020 BUSY with en=0 at any edge: abort to IDLE; no complete; quotient/remainder keep prior values.
REQ-021 Input changes during BUSY are ignored; only captured copies are used.
REQ-022 Signed fixup: quotient negated iff operand signs differ; remainder takes the dividend's sign.
REQ-023 Signed fixup results wrap modulo 2^32.
REQ-024 Signed overflow: 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0.
REQ-025 Divisor zero, either signedness: quotient=0xFFFFFFFF, remainder=dividend; no sign fixup applied; no exception.
REQ-026 Divisor zero keeps the normal 33-edge latency.
REQ-027 quotient/remainder change only on entry to DONE or on reset.

Reset
REQ-028 aresetn=0 at an edge forces: state IDLE, counter 0, complete 0, quotient 0, remainder 0.
REQ-029 Reset takes priority over en in every state.
REQ-030 Reset during BUSY aborts the op; no complete follows.
REQ-031 First capture is possible at the first edge with aresetn=1 and en=1.

Structure
REQ-032 DType (32-bit) is taken from shared package cpuDefine.
REQ-033 Constant DIV_ITER=32 is added to cpuDefine.
REQ-034 FSM state enum is local to seq_divider.
REQ-035 No sub-module; single module, target 120-250 lines.
REQ-036 The ALU instantiates seq_divider in place of its current divider, with the same port connections.

Verification
REQ-037 Unsigned: is_signed=0, 100/7 -> quotient=14, remainder=2, complete high in the cycle after the 33rd edge.
REQ-038 Signed: 0xFFFFFFF9 / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
REQ-039 Signed overflow: 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-040 Divide by zero: 0x12345678 / 0, both is_signed values -> quotient=0xFFFFFFFF, remainder=0x12345678.
REQ-041 Back-to-back: en held high through complete; operands switched to 9/3 in the cycle after complete -> second complete 34 edges after the first, quotient=3, remainder=0, no duplicate of the first result.
REQ-042 Abort: en dropped on edge 10 of BUSY -> no complete, state IDLE, outputs unchanged.
REQ-043 Reset abort: aresetn=0 mid-BUSY -> outputs 0, no complete.
